// File: rtl/adder_tree_lane_packer_if.sv
// Sample-in / lane-vector-out handshake bundle for the adder-tree packer.
// slave: packer side; master: producer/consumer (bench) side.
interface adder_tree_lane_packer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 16
);
  localparam int CW = $clog2(LANES + 1);

  logic                        in_valid;
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        in_last;
  logic                        in_ready;
  logic                        out_valid;
  logic [LANES*DATA_WIDTH-1:0] out_data;
  logic [CW-1:0]               out_count;
  logic                        out_ready;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/adder_tree_lane_packer.sv
// Packs a 16-bit sample stream into ping-pong buffered lane vectors.
// Ports: clk, reset (async high), bus (slave: in_* stream, out_* vectors).
module adder_tree_lane_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 16
) (
  input logic                     clk,
  input logic                     reset,
  adder_tree_lane_packer_if.slave bus
);
  localparam int CW = $clog2(LANES + 1);
  localparam int IW = $clog2(LANES);
  localparam int VW = LANES * DATA_WIDTH;

  logic [VW-1:0] vbuf [2];
  logic [CW-1:0] vcnt [2];
  logic          fsel;
  logic          dsel;
  logic [IW-1:0] widx;
  logic [1:0]    full_cnt;

  logic ready;
  logic valid;
  logic in_beat;
  logic out_beat;
  logic commit;

  assign ready = !reset && (full_cnt < 2'd2);
  assign valid = (full_cnt != 2'd0);

  assign in_beat  = bus.in_valid && ready;
  assign out_beat = valid && bus.out_ready;
  assign commit   = in_beat &&
                    (bus.in_last || widx == IW'(LANES - 1));

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.out_data  = valid ? vbuf[dsel] : '0;
  assign bus.out_count = valid ? vcnt[dsel] : '0;

  // Opening beat rewrites the whole buffer so unused lanes read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vbuf[0] <= '0;
      vbuf[1] <= '0;
      vcnt[0] <= '0;
      vcnt[1] <= '0;
    end else if (in_beat) begin
      if (widx == '0)
        vbuf[fsel] <= VW'(bus.in_data);
      else
        vbuf[fsel][widx*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
      if (commit)
        vcnt[fsel] <= CW'(widx) + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsel     <= 1'b0;
      dsel     <= 1'b0;
      widx     <= '0;
      full_cnt <= 2'd0;
    end else begin
      if (commit) begin
        fsel <= !fsel;
        widx <= '0;
      end else if (in_beat) begin
        widx <= widx + 1'b1;
      end
      if (out_beat)
        dsel <= !dsel;
      unique case (1'b1)
        commit && !out_beat: full_cnt <= full_cnt + 2'd1;
        !commit && out_beat: full_cnt <= full_cnt - 2'd1;
        default:             full_cnt <= full_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_tree_lane_packer.sv
// Self-checking bench for adder_tree_lane_packer.
// Queue-based packing model plus directed and random scenarios.
module tb_adder_tree_lane_packer;
  logic clk;
  logic reset;

  adder_tree_lane_packer_if #(.DATA_WIDTH(16), .LANES(16)) bus ();

  adder_tree_lane_packer #(.DATA_WIDTH(16), .LANES(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0]  part [$];
  logic [255:0] exp_d [$];
  int           exp_c [$];
  int           nvec = 0;

  task automatic model_push(input logic [15:0] d, input logic l);
    logic [255:0] v;
    part.push_back(d);
    if (l || part.size() == 16) begin
      v = '0;
      for (int i = 0; i < part.size(); i++)
        v[i*16 +: 16] = part[i];
      exp_d.push_back(v);
      exp_c.push_back(part.size());
      nvec++;
      part.delete();
    end
  endtask

  task automatic cyc(input logic v, input logic [15:0] d,
                     input logic l, input logic ordy,
                     output logic ir, output logic ov,
                     output logic [255:0] od, output logic [4:0] oc);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    #1;
    ir = bus.in_ready;
    ov = bus.out_valid;
    od = bus.out_data;
    oc = bus.out_count;
    if (v && ir) model_push(d, l);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 0; bus.in_data = 0;
    bus.in_last = 0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.out_data !== '0 || bus.out_count !== '0) begin
      errors++;
      $display("FAIL reset_state: ov=%b ir=%b cnt=%0d want 0/0/0",
               bus.out_valid, bus.in_ready, bus.out_count);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_full_vector();
    logic ir, ov; logic [255:0] od; logic [4:0] oc;
    int stalls = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 16'(i), 0, 1, ir, ov, od, oc);
      if (ir !== 1'b1 || ov !== 1'b0) stalls++;
    end
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL full_fill: %0d bad cycles want 0", stalls);
    end
    cyc(0, 0, 0, 1, ir, ov, od, oc);
    checks++;
    if (ov !== 1'b1 || od[15:0] !== 16'h0001 ||
        od[255:240] !== 16'h0010 || oc !== 5'd16) begin
      errors++;
      $display("FAIL full_vec: ov=%b l0=%h l15=%h cnt=%0d want 1/0001/0010/16",
               ov, od[15:0], od[255:240], oc);
    end
    checks++;
    if (exp_d.size() == 0 || od !== exp_d[0]) begin
      errors++;
      $display("FAIL full_model: got %h", od);
    end
    if (exp_d.size() != 0) begin
      void'(exp_d.pop_front()); void'(exp_c.pop_front());
    end
  endtask

  task automatic test_partial();
    logic ir, ov; logic [255:0] od; logic [4:0] oc;
    cyc(1, 16'hAAAA, 0, 1, ir, ov, od, oc);
    cyc(1, 16'hBBBB, 0, 1, ir, ov, od, oc);
    cyc(1, 16'hCCCC, 1, 1, ir, ov, od, oc);
    cyc(0, 0, 0, 1, ir, ov, od, oc);
    checks++;
    if (ov !== 1'b1 || oc !== 5'd3 ||
        od[47:0] !== 48'hCCCC_BBBB_AAAA || od[255:48] !== '0) begin
      errors++;
      $display("FAIL partial: ov=%b cnt=%0d data=%h want cnt 3 CCCCBBBBAAAA",
               ov, oc, od);
    end
    if (exp_d.size() != 0) begin
      void'(exp_d.pop_front()); void'(exp_c.pop_front());
    end
    cyc(1, 16'h1234, 1, 1, ir, ov, od, oc);
    cyc(0, 0, 0, 1, ir, ov, od, oc);
    checks++;
    if (ov !== 1'b1 || oc !== 5'd1 || od !== 256'h1234) begin
      errors++;
      $display("FAIL partial_next: ov=%b cnt=%0d data=%h want 1/1/1234",
               ov, oc, od);
    end
    if (exp_d.size() != 0) begin
      void'(exp_d.pop_front()); void'(exp_c.pop_front());
    end
  endtask

  task automatic test_backpressure();
    logic ir, ov; logic [255:0] od, first; logic [4:0] oc;
    int acc = 0;
    int moved = 0;
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 16'($urandom), 0, 0, ir, ov, od, oc);
      if (ir) acc++;
      if (ov && !seen) begin first = od; seen = 1; end
      else if (seen && od !== first) moved++;
    end
    checks++;
    if (acc != 32 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: acc=%0d ir=%b want 32/0", acc, bus.in_ready);
    end
    checks++;
    if (!seen || moved != 0 || exp_d.size() != 2 || first !== exp_d[0]) begin
      errors++;
      $display("FAIL bp_hold: seen=%0d moved=%0d q=%0d", seen, moved,
               exp_d.size());
    end
    cyc(0, 0, 0, 1, ir, ov, od, oc);
    checks++;
    if (ov !== 1'b1 || exp_d.size() == 0 || od !== exp_d[0]) begin
      errors++;
      $display("FAIL bp_drain1: ov=%b data=%h", ov, od);
    end
    if (exp_d.size() != 0) begin
      void'(exp_d.pop_front()); void'(exp_c.pop_front());
    end
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || exp_d.size() == 0 ||
        bus.out_data !== exp_d[0] || bus.out_count !== 5'd16) begin
      errors++;
      $display("FAIL bp_second: ir=%b cnt=%0d data=%h want ir 1 cnt 16",
               bus.in_ready, bus.out_count, bus.out_data);
    end
    @(negedge clk);
    cyc(0, 0, 0, 1, ir, ov, od, oc);
    if (exp_d.size() != 0) begin
      void'(exp_d.pop_front()); void'(exp_c.pop_front());
    end
  endtask

  task automatic test_single();
    logic ir, ov; logic [255:0] od; logic [4:0] oc;
    int bad = 0;
    for (int i = 0; i < 21; i++) begin
      cyc(i < 20, 16'($urandom), 1, 1, ir, ov, od, oc);
      if (i > 0) begin
        checks++;
        if (ov !== 1'b1 || (i < 20 && ir !== 1'b1) ||
            exp_d.size() == 0 || od !== exp_d[0] || oc !== 5'd1 ||
            od[255:16] !== '0) begin
          errors++; bad++;
          if (bad < 4)
            $display("FAIL single_%0d: ov=%b ir=%b cnt=%0d data=%h",
                     i, ov, ir, oc, od);
        end
        if (exp_d.size() != 0) begin
          void'(exp_d.pop_front()); void'(exp_c.pop_front());
        end
      end
    end
  endtask

  task automatic test_random();
    logic ir, ov, ordy, pstall; logic [255:0] od, pd; logic [4:0] oc, pc;
    int bad = 0;
    int budget = 0;
    int base = nvec;
    pstall = 0;
    while ((nvec - base < 100 || exp_d.size() != 0) && budget < 20000) begin
      budget++;
      ordy = ($urandom_range(0, 9) < 6) || (nvec - base >= 100);
      cyc((nvec - base < 100) && ($urandom_range(0, 9) < 7),
          16'($urandom), ($urandom_range(0, 11) == 0), ordy,
          ir, ov, od, oc);
      if (pstall) begin
        checks++;
        if (ov !== 1'b1 || od !== pd || oc !== pc) begin
          errors++; bad++;
          if (bad < 4) $display("FAIL rand_stall: ov=%b data=%h", ov, od);
        end
      end
      if (ov && ordy) begin
        checks++;
        if (exp_d.size() == 0 || od !== exp_d[0] ||
            32'(oc) !== exp_c[0]) begin
          errors++; bad++;
          if (bad < 4) $display("FAIL rand_vec: cnt=%0d data=%h", oc, od);
        end
        if (exp_d.size() != 0) begin
          void'(exp_d.pop_front()); void'(exp_c.pop_front());
        end
      end
      pstall = ov && !ordy; pd = od; pc = oc;
    end
    checks++;
    if (budget >= 20000 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL rand_done: left=%0d cycles=%0d want 0", exp_d.size(),
               budget);
    end
  endtask

  task automatic test_reset_mid();
    logic ir, ov; logic [255:0] od; logic [4:0] oc;
    int outs = 0;
    for (int i = 0; i < 21; i++)
      cyc(1, 16'($urandom), 0, 0, ir, ov, od, oc);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: ov=%b ir=%b want 0/0", bus.out_valid,
               bus.in_ready);
    end
    part.delete(); exp_d.delete(); exp_c.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      cyc(i < 16, 16'h5000 + 16'(i), 0, 1, ir, ov, od, oc);
      if (ov) begin
        outs++;
        checks++;
        if (exp_d.size() == 0 || od !== exp_d[0] || oc !== 5'd16) begin
          errors++;
          $display("FAIL rst_new: cnt=%0d data=%h", oc, od);
        end
        if (exp_d.size() != 0) begin
          void'(exp_d.pop_front()); void'(exp_c.pop_front());
        end
      end
    end
    checks++;
    if (outs != 1) begin
      errors++;
      $display("FAIL rst_count: %0d vectors want 1", outs);
    end
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_partial();
    test_backpressure();
    test_single();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
